// File: rtl/sdram_pkg.sv
// Shared definitions for the key-triggered SDRAM read sequencer.
package sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DATA_W        = 6;
  localparam int NUM_WORDS_DEF = 4;
  localparam int IDX_W         = 2;

endpackage

// File: rtl/key_debounce.sv
// Push-button synchronizer and debouncer; emits a one-cycle press on a debounced 1->0.
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic s_rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             armed_q;
  logic             press_q;
  logic [1:0]       rdy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rel_cnt_q;

  // armed_q stays low after reset until a debounced release is seen, so a key
  // held through reset cannot produce a press.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      rdy_q     <= 2'b00;
      cnt_q     <= '0;
      rel_cnt_q <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      rdy_q   <= {rdy_q[0], 1'b1};
      press_q <= 1'b0;

      if (sync2_q != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
          press_q  <= armed_q & stable_q & ~sync2_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end

      if (!armed_q) begin
        if (rdy_q[1] && sync2_q) begin
          if (rel_cnt_q == CNT_LAST) armed_q <= 1'b1;
          else rel_cnt_q <= rel_cnt_q + CNT_W'(1);
        end else begin
          rel_cnt_q <= '0;
        end
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/sdram_rd_seq.sv
// Reads NUM_WORDS consecutive SDRAM words per debounced key press and
// presents each captured word to the display stage.
module sdram_rd_seq
  import sdram_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int NUM_WORDS  = NUM_WORDS_DEF,
  parameter int ADDR_W     = 22,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              s_rst_n,
  input  logic              key_n,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_vld,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic [IDX_W-1:0]  dout_idx,
  output logic              busy,
  output logic              err
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  // Address add wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              dout_vld_q;
  logic [IDX_W-1:0]  dout_idx_q;
  logic              busy_q;
  logic              err_q;
  logic              press;
  logic [IDX_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] addr_d;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .s_rst_n(s_rst_n),
    .key_n  (key_n),
    .press  (press)
  );

  assign cnt_d  = cnt_q + IDX_W'(1);
  assign addr_d = addr_add(base_q, cnt_d);

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_idx_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      dout_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (press) begin
            base_q    <= base_addr;
            cnt_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            rd_req_q  <= 1'b1;
            rd_addr_q <= base_addr;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_ack) begin
            rd_req_q <= 1'b0;
            tmo_q    <= '0;
            state_q  <= ST_WAIT;
          end else if (tmo_q == TMO_LAST) begin
            err_q    <= 1'b1;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_WAIT: begin
          if (rd_vld) begin
            dout_q     <= rd_data;
            dout_idx_q <= cnt_q;
            dout_vld_q <= 1'b1;
            if (cnt_q == IDX_LAST) begin
              state_q <= ST_DONE;
            end else begin
              cnt_q     <= cnt_d;
              rd_addr_q <= addr_d;
              rd_req_q  <= 1'b1;
              tmo_q     <= '0;
              state_q   <= ST_REQ;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dout_idx = dout_idx_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sdram_rd_seq.sv
// Bench for sdram_rd_seq: table rows, hand-written corner sequences and random runs.
module tb_sdram_rd_seq;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          s_rst_n;
  logic          key_n;
  logic [AW-1:0] base_addr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          rd_vld;
  logic [5:0]    rd_data;
  logic [5:0]    dout;
  logic          dout_vld;
  logic [1:0]    dout_idx;
  logic          busy;
  logic          err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdram_rd_seq #(
    .DEB_CYCLES(4),
    .NUM_WORDS (4),
    .ADDR_W    (AW),
    .TIMEOUT   (16)
  ) dut (
    .clk      (clk),
    .s_rst_n  (s_rst_n),
    .key_n    (key_n),
    .base_addr(base_addr),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_vld   (rd_vld),
    .rd_data  (rd_data),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_idx (dout_idx),
    .busy     (busy),
    .err      (err)
  );

  typedef struct {
    logic [AW-1:0] base;
    int            ack_dly;
    int            vld_dly;
    logic [23:0]   data;
    bit            stray;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t tbl[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference address: base plus word number, modulo 2^22.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] b, input int i);
    longint s;
    s = longint'(b) + longint'(i);
    return AW'(s % 4194304);
  endfunction

  task automatic press_key();
    key_n = 1'b0;
    repeat (10) @(negedge clk);
    key_n = 1'b1;
  endtask

  task automatic idle_check(input int cycles, input string name);
    int hits = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (rd_req) hits++;
    end
    check(name, 32'(hits), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_req"},   32'(rd_req),   32'd0);
    check({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
    check({tag, "_dout"},     32'(dout),     32'd0);
    check({tag, "_dout_vld"}, 32'(dout_vld), 32'd0);
    check({tag, "_dout_idx"}, 32'(dout_idx), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!rd_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", 32'(rd_req), 32'd1);
    ok = rd_req;
  endtask

  // One full press-and-read sequence acting as the SDRAM controller.
  task automatic run_seq(input logic [AW-1:0] base, input int ack_dly, input int vld_dly,
                         input logic [23:0] data, input bit stray, input bit extra_press,
                         output logic [AW-1:0] last);
    bit         ok;
    logic [5:0] w;
    last = '0;
    base_addr = base;
    fork
      press_key();
    join_none
    for (int i = 0; i < 4; i++) begin
      w = data[6*i +: 6];
      wait_req(ok);
      if (!ok) return;
      if (extra_press && i == 1) begin
        fork
          press_key();
        join_none
      end
      check("busy_in_seq", 32'(busy), 32'd1);
      if (i == 0) check("err_clear", 32'(err), 32'd0);
      check("rd_addr", 32'(rd_addr), 32'(model_addr(base, i)));
      last = rd_addr;
      repeat (ack_dly) @(negedge clk);
      check("req_held", 32'(rd_req), 32'd1);
      rd_ack = 1'b1;
      if (stray) begin
        rd_vld  = 1'b1;
        rd_data = ~w;
      end
      @(negedge clk);
      rd_ack = 1'b0;
      rd_vld = 1'b0;
      check("req_drop", 32'(rd_req), 32'd0);
      check("no_vld_on_ack", 32'(dout_vld), 32'd0);
      repeat (vld_dly) @(negedge clk);
      rd_vld  = 1'b1;
      rd_data = w;
      @(negedge clk);
      rd_vld = 1'b0;
      check("dout_vld", 32'(dout_vld), 32'd1);
      check("dout", 32'(dout), 32'(w));
      check("dout_idx", 32'(dout_idx), 32'(i));
    end
    check("busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("vld_single", 32'(dout_vld), 32'd0);
    check("err_end", 32'(err), 32'd0);
    check("dout_hold", 32'(dout), 32'(data[23:18]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] last;
    bit            ok;
    int            n;

    tbl[0] = '{22'h000100, 2, 1, {6'd1, 6'd4, 6'd1, 6'd3}, 1'b0, 22'h000103};
    tbl[1] = '{22'h3FFFFE, 0, 0, {6'd9, 6'd8, 6'd7, 6'd6}, 1'b0, 22'h000001};
    tbl[2] = '{22'h000000, 5, 3, {6'd21, 6'd42, 6'd0, 6'd63}, 1'b1, 22'h000003};

    s_rst_n   = 1'b1;
    key_n     = 1'b1;
    base_addr = '0;
    rd_ack    = 1'b0;
    rd_vld    = 1'b0;
    rd_data   = '0;
    #1 s_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    s_rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      run_seq(tbl[r].base, tbl[r].ack_dly, tbl[r].vld_dly, tbl[r].data, tbl[r].stray, 1'b0, last);
      check("tbl_last_addr", 32'(last), 32'(tbl[r].exp_last));
      idle_check(12, "tbl_idle");
    end

    // Short glitches never survive the debounce window.
    repeat (4) begin
      key_n = 1'b0;
      repeat (2) @(negedge clk);
      key_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    idle_check(30, "glitch_no_req");
    check("glitch_busy", 32'(busy), 32'd0);

    // Second press while busy is ignored: exactly four reads.
    run_seq(22'h000040, 3, 3, {6'd5, 6'd6, 6'd7, 6'd8}, 1'b0, 1'b1, last);
    idle_check(30, "busy_press_ignored");

    // Read data never arrives after the first ack.
    base_addr = 22'h000055;
    fork
      press_key();
    join_none
    wait_req(ok);
    repeat (2) @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'd16);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_req", 32'(rd_req), 32'd0);
    rd_vld  = 1'b1;
    rd_data = 6'd33;
    @(negedge clk);
    rd_vld = 1'b0;
    check("idle_vld_ignored", 32'(dout_vld), 32'd0);
    check("err_sticky", 32'(err), 32'd1);
    repeat (12) @(negedge clk);
    run_seq(22'h000123, 1, 2, {6'd12, 6'd34, 6'd56, 6'd10}, 1'b0, 1'b0, last);
    idle_check(12, "after_tmo_idle");

    // Reset asserted mid-sequence while waiting for data.
    base_addr = 22'h000200;
    fork
      press_key();
    join_none
    wait_req(ok);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    #2 s_rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    s_rst_n = 1'b1;
    rd_vld  = 1'b1;
    rd_data = 6'd5;
    @(negedge clk);
    rd_vld = 1'b0;
    check("post_rst_vld", 32'(dout_vld), 32'd0);
    check("post_rst_dout", 32'(dout), 32'd0);
    idle_check(20, "post_rst_idle");

    // Key held low through reset release must not start a sequence.
    key_n = 1'b0;
    @(negedge clk);
    s_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    s_rst_n = 1'b1;
    idle_check(25, "held_key_no_press");
    key_n = 1'b1;
    repeat (15) @(negedge clk);
    run_seq(22'h0ABCDE, 2, 2, {6'd44, 6'd33, 6'd22, 6'd11}, 1'b0, 1'b0, last);
    check("held_key_last", 32'(last), 32'(model_addr(22'h0ABCDE, 3)));
    idle_check(12, "held_key_idle");

    for (int r = 0; r < 6; r++) begin
      logic [AW-1:0] b;
      logic [23:0]   d;
      b = AW'($urandom);
      if (r[0]) b = 22'h3FFFFC + AW'($urandom_range(0, 3));
      d = 24'($urandom);
      run_seq(b, $urandom_range(0, 6), $urandom_range(0, 6), d, 1'($urandom_range(0, 1)),
              1'b0, last);
      check("rand_last_addr", 32'(last), 32'(model_addr(b, 3)));
      idle_check(12, "rand_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_rd_seq.md
SDRAM_RD_SEQ -- requirements
Module: sdram_rd_seq

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, sets the key debounce stability window in clk cycles.
REQ-002 Parameter NUM_WORDS, default 4, sets the number of words read per key press.
REQ-003 Parameter ADDR_W, default 22, sets the SDRAM word address width.
REQ-004 Parameter TIMEOUT, default 1024, sets the maximum cycles to wait for read data.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 s_rst_n  in  1  asynchronous active-low reset.
REQ-007 key_n  in  1  raw, asynchronous push button; low = pressed.
REQ-008 base_addr  in  ADDR_W  start address, sampled on an accepted press.
REQ-009 rd_req  out  1  read request to the SDRAM controller.
REQ-010 rd_addr  out  ADDR_W  read address, valid while rd_req=1.
REQ-011 rd_ack  in  1  controller accepted the request, single-cycle pulse.
REQ-012 rd_vld  in  1  read data valid, single-cycle pulse.
REQ-013 rd_data  in  6  read data.
REQ-014 dout  out  6  captured word for the display stage.
REQ-015 dout_vld  out  1  one-cycle strobe per captured word.
REQ-016 dout_idx  out  2  index of the word presented on dout, 0..NUM_WORDS-1.
REQ-017 busy  out  1  high for the whole sequence; drives the display stage key input.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 key_n SHALL pass through a 2-flop synchronizer; the stable level SHALL update only after the synchronized value has differed from it for DEB_CYCLES consecutive cycles.
REQ-020 A press event SHALL be a 1->0 transition of the stable level; it SHALL be a single-cycle event.
REQ-021 States SHALL be IDLE, REQ, WAIT and DONE.
REQ-022 IDLE: on a press event, latch base_addr, clear the word counter, clear err, set busy and go to REQ; press events outside IDLE SHALL be ignored.
REQ-023 REQ: rd_req=1 and rd_addr=latched base + word counter; hold both until rd_ack=1, then drop rd_req in the next cycle and go to WAIT.
REQ-024 WAIT: on rd_vld=1, register rd_data into dout, drive dout_idx=counter and pulse dout_vld one cycle later (latency 1).
REQ-025 After that capture, if the counter equals NUM_WORDS-1, go to DONE; otherwise increment the counter and return to REQ.
REQ-026 rd_vld in any state other than WAIT SHALL be ignored; rd_ack outside REQ SHALL be ignored.
REQ-027 rd_vld in the same cycle as rd_ack SHALL NOT be captured; data SHALL be captured only in WAIT.
REQ-028 A timeout counter SHALL clear on entry to REQ or WAIT; if it reaches TIMEOUT-1 in REQ or WAIT, set err, drop rd_req and busy, and go to IDLE.
REQ-029 DONE: hold busy high for one further cycle, then clear busy and go to IDLE.
REQ-030 The address add SHALL wrap modulo 2^ADDR_W.
REQ-031 dout and dout_idx SHALL hold their last values until the next capture.

Reset
REQ-032 Asserting s_rst_n low at any time, including mid-sequence, SHALL immediately force IDLE and zero the counters.
REQ-033 Reset values: rd_req=0, rd_addr=0, dout=0, dout_vld=0, dout_idx=0, busy=0, err=0.
REQ-034 On reset, the synchronizer and stable level SHALL be set to 1 (released).
REQ-035 Release of s_rst_n with key_n held low SHALL NOT produce a press event until a release and a new press are debounced.

Structure
REQ-036 A shared package sdram_pkg SHALL hold the state enumeration, DATA_W=6 and the default NUM_WORDS.
REQ-037 The debounce logic SHALL be a sub-module key_debounce (ports clk, s_rst_n, key_n, press), instantiated once.

Verification
REQ-038 Test parameters: DEB_CYCLES=4, TIMEOUT=16.
REQ-039 Scenario 1: press held 10 cycles, base_addr=0x100, ack after 2 cycles, data 3,1,4,1 returned -> rd_addr 0x100..0x103, four dout_vld strobes with dout=3,1,4,1 and dout_idx=0..3, busy falls, err=0.
REQ-040 Scenario 2: 2-cycle glitches on key_n -> no rd_req.
REQ-041 Scenario 3: second press during busy -> ignored, exactly 4 reads.
REQ-042 Scenario 4: no rd_vld after the first ack -> err=1 at 16 cycles, busy=0, rd_req=0; the next press clears err.
REQ-043 Scenario 5: base_addr=0x3FFFFE with ADDR_W=22 -> addresses 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001.
REQ-044 Scenario 6: s_rst_n pulsed low while in WAIT -> all outputs at reset values within the same cycle; stray rd_vld afterwards produces no dout_vld.
